// File: rtl/serial_adder_if.sv
// serial_adder_if -- operand/result bundle for the bit-serial adder.
//
// Signals:
//   start  request to begin an addition (master -> slave)
//   a, b   operands, WIDTH bits, sampled with start (master -> slave)
//   cin    carry-in, sampled with start (master -> slave)
//   busy   addition in progress (slave -> master)
//   done   one-cycle pulse marking a new result (slave -> master)
//   sum    registered result, WIDTH bits (slave -> master)
//   cout   registered carry-out (slave -> master)
//
// Handshake: there is no ready signal. start is a single-cycle request that
// the slave accepts on any rising edge where busy=0 (idle or done). While
// busy=1, start, a, b and cin are ignored. Each accepted request produces
// exactly one done pulse, unless reset aborts the operation first. sum and
// cout are valid from the done cycle until the next done.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial adder: one full-adder step per clock, LSB first.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        serial_adder_if.slave (start/a/b/cin in, busy/done/sum/cout out)
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Timing: start accepted at edge N -> WIDTH RUN edges -> done=1 with a valid
// sum/cout in the cycle after edge N+WIDTH. A start seen in DONE is accepted
// immediately, giving one result every WIDTH+1 cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_if.slave       bus,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             step_sum;
  logic             step_carry;
  logic [WIDTH-1:0] psum_next;

  // One full-adder step on the operand LSBs; the new sum bit enters at the
  // MSB so that after WIDTH steps psum holds the result in natural order.
  always_comb begin
    step_sum   = op_a[0] ^ op_b[0] ^ carry;
    step_carry = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    psum_next  = {step_sum, psum[WIDTH-1:1]};
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_a     <= bus.a;
            op_b     <= bus.b;
            carry    <= bus.cin;
            psum     <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        RUN: begin
          psum  <= psum_next;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= step_carry;
          // cnt reaches WIDTH on the final step; CW bits hold WIDTH, so no wrap.
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bus.sum  <= psum_next;
            bus.cout <= step_carry;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
